// File: rtl/axi_mgr_cmd.sv
// axi_mgr_cmd: single-outstanding AXI manager. Each accepted command becomes
// one single-beat AXI write (AW+W+B) or read (AR+R), followed by a one-cycle
// response pulse.
// Optional build macro: AXI_MGR_TIMEOUT_EN adds a per-transaction watchdog
// that abandons a stalled transaction with rsp_resp=2'b11.
module axi_mgr_cmd #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  s_axi_clk,
  input  logic                  s_axi_resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic                  m_axi_wlast,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;

`ifdef AXI_MGR_TIMEOUT_EN
  logic [15:0] tmo_cnt;
`endif

  // Command side is only open in IDLE and never while reset is held.
  assign cmd_ready = (state == IDLE) && s_axi_resetn;

  // Single-beat writes: the only beat is always the last one.
  assign m_axi_wlast = m_axi_wvalid;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

  // Transaction sequencer with registered AXI and response outputs.
  always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
`ifdef AXI_MGR_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
`ifdef AXI_MGR_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR_REQ;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_write    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_write    <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rlast ? m_axi_rresp : 2'b10;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef AXI_MGR_TIMEOUT_EN
      // Placed after the case so an expiring watchdog overrides any
      // same-cycle handshake progress.
      if (state == WR_REQ || state == WR_RESP || state == RD_REQ || state == RD_DATA) begin
        if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b0;
          m_axi_bready  <= 1'b0;
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b0;
          rsp_write     <= (state == WR_REQ) || (state == WR_RESP);
          rsp_rdata     <= '0;
          rsp_resp      <= 2'b11;
          rsp_valid     <= 1'b1;
          state         <= RSP;
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end
`endif
    end
  end

endmodule

// File: doc/axi_mgr_cmd.md
# axi_mgr_cmd

Single-outstanding AXI manager that turns a simple command/response interface into single-beat AXI write (AW+W+B) and read (AR+R) transactions. It drives the subordinate-side CSR bridge used by the FIFO register block and serves as the bus initiator for on-chip bring-up and register sequencing. One transaction is in flight at a time; a new command is accepted only after the previous response has been delivered.

## Interface
- DATA_WIDTH, 8, width of wdata/rdata and command/response data
- ADDR_WIDTH, 8, width of awaddr/araddr and command address
- TIMEOUT_CYCLES, 255, watchdog limit per transaction (used only with AXI_MGR_TIMEOUT_EN)

Ports:
- s_axi_clk  in  1  clock, all logic rising-edge
- s_axi_resetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transaction address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse: transaction complete
- rsp_write  out  1  completed transaction was a write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  final response code
- m_axi_awaddr  out  ADDR_WIDTH ; m_axi_awvalid out 1 ; m_axi_awready in 1
- m_axi_wdata  out  DATA_WIDTH ; m_axi_wvalid out 1 ; m_axi_wready in 1 ; m_axi_wlast out 1
- m_axi_bresp  in  2 ; m_axi_bvalid in 1 ; m_axi_bready out 1
- m_axi_araddr  out  ADDR_WIDTH ; m_axi_arvalid out 1 ; m_axi_arready in 1
- m_axi_rdata  in  DATA_WIDTH ; m_axi_rresp in 2 ; m_axi_rlast in 1 ; m_axi_rvalid in 1 ; m_axi_rready out 1

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On accept, register addr/wdata/write; go WR_REQ (write) or RD_REQ (read).
- WR_REQ: awvalid and wvalid assert together; each drops the cycle after its own handshake (aw_done/w_done flags). Both done -> WR_RESP. AW and W may complete in either order or same cycle.
- WR_RESP: bready=1. On bvalid: capture bresp -> RSP.
- RD_REQ: arvalid=1 until arready -> RD_DATA.
- RD_DATA: rready=1. On rvalid: capture rdata, rresp; if rlast=0 force rsp_resp=2'b10 -> RSP.
- RSP: rsp_valid=1 for exactly one cycle -> IDLE. No backpressure on response.
- wlast tied 1 whenever wvalid=1 (single beat); 0 otherwise.
- Protocol rules: no valid drops before its ready; addr/data stable while valid; bready/rready asserted only in WR_RESP/RD_DATA; no AR while a write is in flight and vice versa.

## Timing
- Reset values: cmd_ready 0 during reset, 1 in IDLE after release; all m_axi valids/readys 0; awaddr/araddr/wdata 0; wlast 0; rsp_valid 0; rsp_write 0; rsp_rdata 0; rsp_resp 0.
- All outputs registered except cmd_ready (decode of state==IDLE).
- Zero-wait subordinate: write accept at cycle 0, AW/W valid cycle 1, bready cycle 2, bvalid sampled cycle 2 -> rsp_valid cycle 3; next cmd accepted cycle 4. Read same: arvalid 1, rready 2, rsp_valid 3.
- Each subordinate wait cycle on any ready/valid adds one cycle.
- Reset mid-transaction: all valids drop immediately (async), FSM to IDLE, transaction abandoned, no rsp_valid.
- bvalid/rvalid arriving outside WR_RESP/RD_DATA ignored (readys low).

## Configuration
- AXI_MGR_TIMEOUT_EN defined: 16-bit counter clears on cmd accept, increments each cycle outside IDLE/RSP; reaching TIMEOUT_CYCLES drops all m_axi valids/readys, goes RSP with rsp_resp=2'b11, rsp_rdata=0.
- Undefined: no counter; FSM waits indefinitely for subordinate.

## Test plan
- Write 0xA5 to 0x10, zero-wait subordinate -> awaddr=0x10, wdata=0xA5, wlast=1 cycle 1; rsp_valid cycle 3, rsp_write=1, rsp_resp=0.
- Read 0x10 returning 0x5A, rresp=0, rlast=1 -> rsp_rdata=0x5A, rsp_resp=0, rsp_write=0.
- Write with awready delayed 3 cycles, wready immediate -> wvalid drops after cycle 1, awvalid held through 4, bready only after both; rsp_valid cycle 6.
- Read with rlast=0 on beat -> rsp_resp=2'b10, rdata still captured.
- Reset asserted while in WR_RESP -> all valids/readys 0 same cycle, no rsp_valid; new read after release completes normally.
- AXI_MGR_TIMEOUT_EN, TIMEOUT_CYCLES=8, arready never asserted -> arvalid drops and rsp_valid with rsp_resp=2'b11 after 8 cycles.
